// File: rtl/ex_stage_controller.sv
// rtl/ex_stage_controller.sv - EX-stage decoder with registered ALU/MUL/result-mux control.
// Define EXC_MEXT_EN to decode the M extension (MUL/DIV/REM).
module ex_stage_controller #(
    parameter int ifuresctl_N = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [6:0]                     opcode,
    input  logic [2:0]                     func3,
    input  logic [1:0]                     func7b50,
    output logic [3:0]                     aluctl,
    output logic [1:0]                     mulctl,
    output logic [$clog2(ifuresctl_N)-1:0] ifuresctl,
    output logic                           illegal
);

    localparam int IW = $clog2(ifuresctl_N);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [3:0] ALU_ADD   = 4'h0;
    localparam logic [3:0] ALU_SUB   = 4'h1;
    localparam logic [3:0] ALU_SLL   = 4'h2;
    localparam logic [3:0] ALU_SLT   = 4'h3;
    localparam logic [3:0] ALU_SLTU  = 4'h4;
    localparam logic [3:0] ALU_XOR   = 4'h5;
    localparam logic [3:0] ALU_SRL   = 4'h6;
    localparam logic [3:0] ALU_SRA   = 4'h7;
    localparam logic [3:0] ALU_OR    = 4'h8;
    localparam logic [3:0] ALU_AND   = 4'h9;
    localparam logic [3:0] ALU_PASSB = 4'hA;

    // Base integer func3 map shared by OP (func7=0) and OP-IMM.
    function automatic logic [3:0] base_alu(input logic [2:0] f3);
        case (f3)
            3'b000:  base_alu = ALU_ADD;
            3'b001:  base_alu = ALU_SLL;
            3'b010:  base_alu = ALU_SLT;
            3'b011:  base_alu = ALU_SLTU;
            3'b100:  base_alu = ALU_XOR;
            3'b101:  base_alu = ALU_SRL;
            3'b110:  base_alu = ALU_OR;
            default: base_alu = ALU_AND;
        endcase
    endfunction

    logic [3:0]    w_aluctl;
    logic [1:0]    w_mulctl;
    logic [IW-1:0] w_ifuresctl;
    logic          w_illegal;

    always_comb begin
        w_aluctl    = ALU_ADD;
        w_mulctl    = 2'b00;
        w_ifuresctl = '0;
        w_illegal   = 1'b0;
        case (opcode)
            OPC_OP: begin
                case (func7b50)
                    2'b00: w_aluctl = base_alu(func3);
                    2'b10: begin
                        if (func3 == 3'b000)      w_aluctl = ALU_SUB;
                        else if (func3 == 3'b101) w_aluctl = ALU_SRA;
                        else                      w_illegal = 1'b1;
                    end
`ifdef EXC_MEXT_EN
                    2'b01: begin
                        w_mulctl = func3[1:0];
                        if (!func3[2])             w_ifuresctl = IW'(1);
                        else if (ifuresctl_N >= 3) w_ifuresctl = IW'(2);
                        else                       w_illegal = 1'b1;
                    end
`else
                    2'b01: w_illegal = 1'b1;
`endif
                    default: w_illegal = 1'b1;
                endcase
            end
            OPC_OPIMM: begin
                case (func3)
                    3'b001: begin
                        if (func7b50 == 2'b00) w_aluctl = ALU_SLL;
                        else                   w_illegal = 1'b1;
                    end
                    3'b101: begin
                        if (func7b50 == 2'b00)      w_aluctl = ALU_SRL;
                        else if (func7b50 == 2'b10) w_aluctl = ALU_SRA;
                        else                        w_illegal = 1'b1;
                    end
                    default: w_aluctl = base_alu(func3);
                endcase
            end
            OPC_LOAD, OPC_STORE, OPC_AUIPC, OPC_JAL, OPC_JALR: w_aluctl = ALU_ADD;
            OPC_LUI: w_aluctl = ALU_PASSB;
            OPC_BRANCH: begin
                case (func3)
                    3'b000, 3'b001: w_aluctl = ALU_SUB;
                    3'b100, 3'b101: w_aluctl = ALU_SLT;
                    3'b110, 3'b111: w_aluctl = ALU_SLTU;
                    default:        w_illegal = 1'b1;
                endcase
            end
            default: w_illegal = 1'b1;
        endcase
        // Illegal encodings always present safe, inert controls downstream.
        if (w_illegal) begin
            w_aluctl    = ALU_ADD;
            w_mulctl    = 2'b00;
            w_ifuresctl = '0;
        end
    end

    logic [3:0]    r_aluctl;
    logic [1:0]    r_mulctl;
    logic [IW-1:0] r_ifuresctl;
    logic          r_illegal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_aluctl    <= 4'h0;
            r_mulctl    <= 2'b00;
            r_ifuresctl <= '0;
            r_illegal   <= 1'b0;
        end else begin
            r_aluctl    <= w_aluctl;
            r_mulctl    <= w_mulctl;
            r_ifuresctl <= w_ifuresctl;
            r_illegal   <= w_illegal;
        end
    end

    assign aluctl    = r_aluctl;
    assign mulctl    = r_mulctl;
    assign ifuresctl = r_ifuresctl;
    assign illegal   = r_illegal;

endmodule

// File: tb/tb_ex_stage_controller.sv
// tb/tb_ex_stage_controller.sv - directed self-checking bench for ex_stage_controller (N=2 and N=3 instances).
module tb_ex_stage_controller;

    typedef struct packed {
        logic [3:0] alu;
        logic [1:0] mul;
        logic [1:0] sel;
        logic       ill;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [6:0] opcode;
    logic [2:0] func3;
    logic [1:0] func7b50;

    logic [3:0] aluctl2, aluctl3;
    logic [1:0] mulctl2, mulctl3;
    logic [0:0] ifuresctl2;
    logic [1:0] ifuresctl3;
    logic       illegal2, illegal3;

    int errors = 0;
    int checks = 0;
    logic [3:0] prev_alu;

    ex_stage_controller #(.ifuresctl_N(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .func3(func3), .func7b50(func7b50),
        .aluctl(aluctl2), .mulctl(mulctl2), .ifuresctl(ifuresctl2), .illegal(illegal2)
    );

    ex_stage_controller #(.ifuresctl_N(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .func3(func3), .func7b50(func7b50),
        .aluctl(aluctl3), .mulctl(mulctl3), .ifuresctl(ifuresctl3), .illegal(illegal3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t E(input logic [3:0] a, input logic [1:0] m,
                               input logic [1:0] s, input logic i);
        E = '{alu: a, mul: m, sel: s, ill: i};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input exp_t e2, input exp_t e3);
        check({tag, " n2.alu"}, 32'(aluctl2), 32'(e2.alu));
        check({tag, " n2.mul"}, 32'(mulctl2), 32'(e2.mul));
        check({tag, " n2.sel"}, 32'(ifuresctl2), 32'(e2.sel));
        check({tag, " n2.ill"}, 32'(illegal2), 32'(e2.ill));
        check({tag, " n3.alu"}, 32'(aluctl3), 32'(e3.alu));
        check({tag, " n3.mul"}, 32'(mulctl3), 32'(e3.mul));
        check({tag, " n3.sel"}, 32'(ifuresctl3), 32'(e3.sel));
        check({tag, " n3.ill"}, 32'(illegal3), 32'(e3.ill));
    endtask

    // Drive fields, confirm the old result still holds before the edge, then check one cycle later.
    task automatic step(input string tag, input logic [6:0] op, input logic [2:0] f3,
                        input logic [1:0] f7, input exp_t e2, input exp_t e3);
        opcode   = op;
        func3    = f3;
        func7b50 = f7;
        #3;
        check({tag, " hold"}, 32'(aluctl2), 32'(prev_alu));
        @(posedge clk);
        #1;
        check_all(tag, e2, e3);
        prev_alu = e2.alu;
    endtask

    localparam logic [6:0] OP = 7'b0110011, OPIMM = 7'b0010011, LOAD = 7'b0000011,
                           STORE = 7'b0100011, AUIPC = 7'b0010111, JAL = 7'b1101111,
                           JALR = 7'b1100111, LUI = 7'b0110111, BRANCH = 7'b1100011;

    initial begin
        exp_t ill;
        exp_t z;
        ill = E(4'h0, 2'd0, 2'd0, 1'b1);
        z   = E(4'h0, 2'd0, 2'd0, 1'b0);

        rst_n    = 1'b0;
        opcode   = LUI;
        func3    = 3'b000;
        func7b50 = 2'b00;
        #2;
        check_all("reset", z, z);
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_all("lui_first", E(4'hA, 0, 0, 0), E(4'hA, 0, 0, 0));

        // Asynchronous reset in the middle of a cycle.
        #3;
        rst_n = 1'b0;
        #1;
        check_all("async_reset", z, z);
        #1;
        rst_n    = 1'b1;
        prev_alu = 4'h0;

        step("op_sub",    OP, 3'b000, 2'b10, E(4'h1, 0, 0, 0), E(4'h1, 0, 0, 0));
        step("op_and",    OP, 3'b111, 2'b00, E(4'h9, 0, 0, 0), E(4'h9, 0, 0, 0));
        step("op_srl",    OP, 3'b101, 2'b00, E(4'h6, 0, 0, 0), E(4'h6, 0, 0, 0));
        step("op_sra",    OP, 3'b101, 2'b10, E(4'h7, 0, 0, 0), E(4'h7, 0, 0, 0));
        step("op_sltu",   OP, 3'b011, 2'b00, E(4'h4, 0, 0, 0), E(4'h4, 0, 0, 0));
        step("op_f7_10",  OP, 3'b001, 2'b10, ill, ill);
        step("op_f7_11",  OP, 3'b000, 2'b11, ill, ill);
        step("imm_sra",   OPIMM, 3'b101, 2'b10, E(4'h7, 0, 0, 0), E(4'h7, 0, 0, 0));
        step("imm_sr_01", OPIMM, 3'b101, 2'b01, ill, ill);
        step("imm_addi",  OPIMM, 3'b000, 2'b10, E(4'h0, 0, 0, 0), E(4'h0, 0, 0, 0));
        step("imm_slli",  OPIMM, 3'b001, 2'b00, E(4'h2, 0, 0, 0), E(4'h2, 0, 0, 0));
        step("imm_sll10", OPIMM, 3'b001, 2'b10, ill, ill);
        step("imm_ori",   OPIMM, 3'b110, 2'b01, E(4'h8, 0, 0, 0), E(4'h8, 0, 0, 0));
        step("imm_xori",  OPIMM, 3'b100, 2'b00, E(4'h5, 0, 0, 0), E(4'h5, 0, 0, 0));
`ifdef EXC_MEXT_EN
        step("m_mulhu",   OP, 3'b011, 2'b01, E(4'h0, 2'd3, 2'd1, 0), E(4'h0, 2'd3, 2'd1, 0));
        step("m_rem",     OP, 3'b110, 2'b01, ill, E(4'h0, 2'd2, 2'd2, 0));
        step("m_div",     OP, 3'b100, 2'b01, ill, E(4'h0, 2'd0, 2'd2, 0));
`else
        step("m_mulhu",   OP, 3'b011, 2'b01, ill, ill);
        step("m_rem",     OP, 3'b110, 2'b01, ill, ill);
`endif
        step("load",      LOAD,  3'b010, 2'b10, E(4'h0, 0, 0, 0), E(4'h0, 0, 0, 0));
        step("lui",       LUI,   3'b000, 2'b00, E(4'hA, 0, 0, 0), E(4'hA, 0, 0, 0));
        step("store",     STORE, 3'b010, 2'b00, E(4'h0, 0, 0, 0), E(4'h0, 0, 0, 0));
        step("br_bltu",   BRANCH, 3'b110, 2'b00, E(4'h4, 0, 0, 0), E(4'h4, 0, 0, 0));
        step("auipc",     AUIPC, 3'b000, 2'b00, E(4'h0, 0, 0, 0), E(4'h0, 0, 0, 0));
        step("br_beq",    BRANCH, 3'b000, 2'b00, E(4'h1, 0, 0, 0), E(4'h1, 0, 0, 0));
        step("br_bge",    BRANCH, 3'b101, 2'b00, E(4'h3, 0, 0, 0), E(4'h3, 0, 0, 0));
        step("br_010",    BRANCH, 3'b010, 2'b00, ill, ill);
        step("jal",       JAL,   3'b000, 2'b00, E(4'h0, 0, 0, 0), E(4'h0, 0, 0, 0));
        step("lui2",      LUI,   3'b111, 2'b11, E(4'hA, 0, 0, 0), E(4'hA, 0, 0, 0));
        step("jalr",      JALR,  3'b000, 2'b00, E(4'h0, 0, 0, 0), E(4'h0, 0, 0, 0));
        step("op_7f",     7'h7F, 3'b000, 2'b00, ill, ill);
        step("op_or",     OP, 3'b110, 2'b00, E(4'h8, 0, 0, 0), E(4'h8, 0, 0, 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
